nibble_mayor_nin: RTL and testbench
===================================

# nibble_mayor_nin

Parametrised, pipelined maximum selector generalising the two-input nibble comparator to `NUM_IN` channels of `WIDTH` bits. Each cycle it can accept one sample vector and returns the largest value and its channel index after a fixed latency. It also offers a running-maximum mode that accumulates across samples until cleared. The block sits in the comparison datapath, downstream of the operand registers, and feeds the result/flag logic.

## Interface

- `WIDTH`, default 4, bit width of each channel value (1..32).
- `NUM_IN`, default 4, number of input channels (2..16).
- Derived: `LEVELS = clog2(NUM_IN)`, `IDXW = max(1, clog2(NUM_IN))`.

Ports:

- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `nmn_in` input `NUM_IN*WIDTH`: channel `i` occupies bits `[i*WIDTH +: WIDTH]`; unsigned.
- `nmn_valid` input 1: sample vector on `nmn_in` is accepted at this edge.
- `nmn_mode` input 1: 0 = per-sample maximum, 1 = running maximum. Sampled together with the data.
- `nmn_clear` input 1: clears the running accumulator; acts at the output stage.
- `nmn_mayor` output `WIDTH`: maximum value.
- `nmn_idx` output `IDXW`: channel index of `nmn_mayor`.
- `nmn_valid_out` output 1: one-cycle pulse per delivered result.

## Operation

**Comparator tree**
- Binary tree of `LEVELS` registered compare stages.
- Each node forwards `{value, idx, valid, mode}` of the larger operand.
- Tie rule: the lower index wins.
- If `NUM_IN` is not a power of two, missing leaves are padded with value 0 at indices above `NUM_IN-1`. Because ties favour the lower index, a pad never wins.
- `nmn_valid` and `nmn_mode` travel down the pipeline with their data. The pipeline never stalls, so a new sample may be accepted every cycle.

**Output stage.** Holds the accumulator `acc_val`, `acc_idx`, `acc_ok`. When a tree result `r` arrives:
- Mode 0: `acc <= r`.
- Mode 1 with `acc_ok=0`: `acc <= r`.
- Mode 1 with `acc_ok=1`: `acc` keeps its value if `acc_val >= r.val`, otherwise `acc <= r`. Equal values keep the older index.
- Every arriving result sets `acc_ok=1` and pulses `nmn_valid_out`.
- `nmn_mayor` / `nmn_idx` are driven directly from `acc_val` / `acc_idx`.

**Clear**
- `nmn_clear` with no result arriving: `acc_val=0`, `acc_idx=0`, `acc_ok=0`, `nmn_valid_out=0`.
- `nmn_clear` in the same cycle as an arriving result: clear is applied first, then the result loads as if `acc_ok=0`, and `nmn_valid_out=1`.
- In-flight tree samples are not affected by clear.

**Mode changes.** A mode change only affects samples accepted from that edge onward. A mode-0 result overwrites the accumulator but leaves `acc_ok=1`, so a later mode-1 sample compares against it.

**Idle.** With no arriving result, the outputs hold their values and `nmn_valid_out=0`.

**Reset.** Reset has priority over everything. It clears all pipeline valids and the accumulator. In-flight samples are dropped and never produce `nmn_valid_out`.

## Timing

- Sample accepted at edge k → result on the outputs after edge k+`LEVELS` (tree registers at k..k+`LEVELS`-1, output register at k+`LEVELS`).
- Example latencies: `NUM_IN`=2 gives 1 cycle; `NUM_IN`=4 gives 2 cycles; `NUM_IN`=16 gives 4 cycles.
- Throughput: one result per cycle. N consecutive valid samples produce N consecutive `nmn_valid_out` pulses, in order.
- Reset values: `nmn_mayor=0`, `nmn_idx=0`, `nmn_valid_out=0`, all internal valids 0, `acc_ok=0`.
- First valid sample after reset release: a sample accepted at the first edge with `reset=0` is honoured.
- `nmn_clear` takes effect at the edge where it is sampled, with no pipeline delay.

## Test plan

All scenarios use `WIDTH`=4, `NUM_IN`=4 unless noted.

1. **Reset:** `reset=1` for 2 cycles with `nmn_in={F,F,F,F}` and `nmn_valid=1` → `nmn_mayor=0`, `nmn_idx=0`, `nmn_valid_out=0` throughout, and no pulse `LEVELS` cycles after release from pre-release data.
2. **Mode 0, tie:** single sample `{in0..in3}={3,9,9,2}` at edge k → after k+2, `nmn_mayor=9`, `nmn_idx=1`, `nmn_valid_out` high exactly one cycle. Outputs then hold 9/1 with valid low.
3. **Sweep and throughput:** back-to-back sweep of `in0`,`in1` over 0..15 (256 samples, `in2=in3=0`), mode 0 → 256 contiguous valid pulses, each matching a reference model, with ties resolved to the lowest index.
4. **Running mode and clear:** samples `{2,1,0,0}`, `{1,7,0,0}`, `{5,5,5,5}` in mode 1 → 2/0, 7/1, 7/1. Then sample `{1,0,0,0}` with `nmn_clear` aligned to its arrival → 1/0. Then `nmn_clear` alone → 0/0 with valid low.
5. **Reset mid-flight:** valid sample `{0,0,0,C}` at edge k, `reset=1` at edge k+1 → no `nmn_valid_out`, outputs 0/0.
6. **Non-power-of-two config** (`WIDTH`=8, `NUM_IN`=3, latency 2): sample `{0,0,0}` → 0/0. Sample `{10,FF,FF}` → FF/1.

Source files
------------

// File: rtl/nibble_mayor_nin.sv
// nibble_mayor_nin: pipelined NUM_IN-way maximum selector with running-max accumulator
module nibble_mayor_nin #(
  parameter int WIDTH = 4,
  parameter int NUM_IN = 4,
  localparam int LEVELS = $clog2(NUM_IN),
  localparam int IDXW = LEVELS > 0 ? LEVELS : 1
) (
  input logic clk,
  input logic reset,
  input logic [NUM_IN*WIDTH-1:0] nmn_in,
  input logic nmn_valid,
  input logic nmn_mode,
  input logic nmn_clear,
  output logic [WIDTH-1:0] nmn_mayor,
  output logic [IDXW-1:0] nmn_idx,
  output logic nmn_valid_out
);
  localparam int LEAVES = 1 << LEVELS;
  logic [WIDTH-1:0] leaf_val [LEAVES];
  logic [IDXW-1:0] leaf_idx [LEAVES];
  logic [WIDTH-1:0] node_val [1:LEAVES-1];
  logic [IDXW-1:0] node_idx [1:LEAVES-1];
  logic [LEVELS-1:0] vld, mode;
  logic acc_ok, load;
  genvar n;
  for (n = 0; n < LEAVES; n++) begin : g_leaf
    if (n < NUM_IN) begin : g_in
      assign leaf_val[n] = nmn_in[n*WIDTH +: WIDTH];
    end else begin : g_pad
      assign leaf_val[n] = '0;
    end
    assign leaf_idx[n] = IDXW'(n);
  end
  for (n = 1; n < LEAVES; n++) begin : g_node
    logic [WIDTH-1:0] a_val, b_val;
    logic [IDXW-1:0] a_idx, b_idx;
    if (2*n >= LEAVES) begin : g_from_leaf
      assign a_val = leaf_val[2*n-LEAVES];
      assign b_val = leaf_val[2*n+1-LEAVES];
      assign a_idx = leaf_idx[2*n-LEAVES];
      assign b_idx = leaf_idx[2*n+1-LEAVES];
    end else begin : g_from_node
      assign a_val = node_val[2*n];
      assign b_val = node_val[2*n+1];
      assign a_idx = node_idx[2*n];
      assign b_idx = node_idx[2*n+1];
    end
    always_ff @(posedge clk) begin
      node_val[n] <= b_val > a_val ? b_val : a_val;
      node_idx[n] <= b_val > a_val ? b_idx : a_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      mode <= '0;
    end else begin
      vld <= LEVELS'({vld, nmn_valid});
      mode <= LEVELS'({mode, nmn_mode});
    end
  end
  assign load = !mode[LEVELS-1] || nmn_clear || !acc_ok || node_val[1] > nmn_mayor;
  always_ff @(posedge clk) begin
    if (reset) begin
      nmn_mayor <= '0;
      nmn_idx <= '0;
      acc_ok <= 1'b0;
      nmn_valid_out <= 1'b0;
    end else begin
      nmn_valid_out <= vld[LEVELS-1];
      if (vld[LEVELS-1]) begin
        acc_ok <= 1'b1;
        if (load) begin
          nmn_mayor <= node_val[1];
          nmn_idx <= node_idx[1];
        end
      end else if (nmn_clear) begin
        nmn_mayor <= '0;
        nmn_idx <= '0;
        acc_ok <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nibble_mayor_nin.sv
// tb_nibble_mayor_nin: vector table, cycle scoreboard and corner sequences for nibble_mayor_nin
module tb_nibble_mayor_nin;
  localparam int LV = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] nmn_in = '0;
  logic nmn_valid = 1'b0, nmn_mode = 1'b0, nmn_clear = 1'b0;
  logic [3:0] mayor;
  logic [1:0] idx;
  logic vout;
  logic [23:0] in3 = '0;
  logic v3 = 1'b0;
  logic [7:0] mayor3;
  logic [1:0] idx3;
  logic vout3;
  int total = 0, bad = 0, cyc = 0, pulses = 0, p0;
  typedef struct {logic [3:0] v; logic [1:0] i; logic m; int due;} item_t;
  typedef struct {logic [15:0] d; logic [3:0] em; logic [1:0] ei;} vec_t;
  item_t q[$];
  item_t r;
  logic [3:0] m_acc = '0;
  logic [1:0] m_idx = '0;
  logic m_ok = 1'b0, m_vo = 1'b0, m_load;
  vec_t vt[7];
  nibble_mayor_nin #(.WIDTH(4), .NUM_IN(4)) dut (
    .clk(clk), .reset(reset), .nmn_in(nmn_in), .nmn_valid(nmn_valid), .nmn_mode(nmn_mode),
    .nmn_clear(nmn_clear), .nmn_mayor(mayor), .nmn_idx(idx), .nmn_valid_out(vout)
  );
  nibble_mayor_nin #(.WIDTH(8), .NUM_IN(3)) dut3 (
    .clk(clk), .reset(reset), .nmn_in(in3), .nmn_valid(v3), .nmn_mode(1'b0),
    .nmn_clear(1'b0), .nmn_mayor(mayor3), .nmn_idx(idx3), .nmn_valid_out(vout3)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic void pmax(input logic [15:0] d, output logic [3:0] v, output logic [1:0] ix);
    v = d[3:0];
    ix = 2'd0;
    for (int i = 1; i < 4; i++)
      if (d[i*4 +: 4] > v) begin
        v = d[i*4 +: 4];
        ix = 2'(i);
      end
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      m_acc = '0;
      m_idx = '0;
      m_ok = 1'b0;
      m_vo = 1'b0;
    end else begin
      m_vo = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        m_load = !r.m || nmn_clear || !m_ok || r.v > m_acc;
        if (m_load) begin
          m_acc = r.v;
          m_idx = r.i;
        end
        m_ok = 1'b1;
        m_vo = 1'b1;
      end else if (nmn_clear) begin
        m_acc = '0;
        m_idx = '0;
        m_ok = 1'b0;
      end
      if (nmn_valid) begin
        pmax(nmn_in, r.v, r.i);
        r.m = nmn_mode;
        r.due = cyc + LV;
        q.push_back(r);
      end
    end
  end
  always @(negedge clk) begin
    check("sb_valid", vout, m_vo);
    check("sb_mayor", mayor, m_acc);
    check("sb_idx", idx, m_idx);
    if (vout) pulses++;
  end
  task automatic step(input logic [15:0] d, input logic v, input logic m, input logic c);
    nmn_in = d;
    nmn_valid = v;
    nmn_mode = m;
    nmn_clear = c;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string name, input logic v, input logic [3:0] m, input logic [1:0] i);
    check({name, "_v"}, vout, v);
    check({name, "_m"}, mayor, m);
    check({name, "_i"}, idx, i);
  endtask
  initial begin
    vt = '{
      '{16'h2993, 4'h9, 2'd1}, '{16'h0000, 4'h0, 2'd0}, '{16'hF00F, 4'hF, 2'd0},
      '{16'h4321, 4'h4, 2'd3}, '{16'h5555, 4'h5, 2'd0}, '{16'h8800, 4'h8, 2'd2},
      '{16'hE1E7, 4'hE, 2'd1}
    };
    reset = 1'b1;
    step(16'hFFFF, 1, 0, 0);
    expect_out("rst0", 0, 0, 0);
    step(16'hFFFF, 1, 0, 0);
    expect_out("rst1", 0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < LV + 1; k++) begin
      step(16'h0000, 0, 0, 0);
      expect_out("rst_release", 0, 0, 0);
    end
    foreach (vt[k]) begin
      step(vt[k].d, 1, 0, 0);
      step(16'h0000, 0, 0, 0);
      check("vec_pre", vout, 1'b0);
      step(16'h0000, 0, 0, 0);
      expect_out("vec", 1, vt[k].em, vt[k].ei);
      step(16'h0000, 0, 0, 0);
      expect_out("vec_hold", 0, vt[k].em, vt[k].ei);
    end
    p0 = pulses;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step({8'h00, 4'(b), 4'(a)}, 1, 0, 0);
    for (int k = 0; k < LV + 2; k++) step(16'h0000, 0, 0, 0);
    check("sweep_pulses", pulses - p0, 256);
    step(16'h0000, 0, 0, 1);
    expect_out("pre_clear", 0, 0, 0);
    step(16'h0012, 1, 1, 0);
    step(16'h0071, 1, 1, 0);
    step(16'h5555, 1, 1, 0);
    expect_out("run0", 1, 4'h2, 2'd0);
    step(16'h0000, 0, 0, 0);
    expect_out("run1", 1, 4'h7, 2'd1);
    step(16'h0000, 0, 0, 0);
    expect_out("run2", 1, 4'h7, 2'd1);
    step(16'h0001, 1, 1, 0);
    step(16'h0000, 0, 0, 0);
    step(16'h0000, 0, 0, 1);
    expect_out("clr_arrive", 1, 4'h1, 2'd0);
    step(16'h0000, 0, 0, 1);
    expect_out("clr_alone", 0, 4'h0, 2'd0);
    step(16'h0000, 0, 0, 0);
    step(16'h0009, 1, 0, 0);
    step(16'h0000, 0, 0, 0);
    step(16'h0000, 0, 0, 0);
    expect_out("m0_after_clr", 1, 4'h9, 2'd0);
    step(16'h0003, 1, 1, 0);
    step(16'h0000, 0, 0, 0);
    step(16'h0000, 0, 0, 0);
    expect_out("m1_vs_m0", 1, 4'h9, 2'd0);
    step(16'hC000, 1, 0, 0);
    reset = 1'b1;
    step(16'h0000, 0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < LV + 1; k++) begin
      step(16'h0000, 0, 0, 0);
      expect_out("rst_flight", 0, 0, 0);
    end
    in3 = 24'h000000;
    v3 = 1'b1;
    step(16'h0000, 0, 0, 0);
    in3 = {8'hFF, 8'hFF, 8'h10};
    step(16'h0000, 0, 0, 0);
    v3 = 1'b0;
    in3 = '0;
    check("n3_zero_v", vout3, 1'b0);
    step(16'h0000, 0, 0, 0);
    check("n3_zero_v", vout3, 1'b1);
    check("n3_zero_m", mayor3, 8'h00);
    check("n3_zero_i", idx3, 2'd0);
    step(16'h0000, 0, 0, 0);
    check("n3_ff_v", vout3, 1'b1);
    check("n3_ff_m", mayor3, 8'hFF);
    check("n3_ff_i", idx3, 2'd1);
    step(16'h0000, 0, 0, 0);
    check("n3_idle_v", vout3, 1'b0);
    check("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
